// File: rtl/layer_addr_pipe_if.sv
// Query/result bundle between the ALU address stage and the pixel-fetch unit.
// master drives queries and accepts results; slave is the address pipeline.
interface layer_addr_pipe_if #(
  parameter int DIM_W        = 16,
  parameter int FRAME_W      = 8,
  parameter int ADDR_W       = 27,
  parameter int GLYPH_W_LOG2 = 3,
  parameter int GLYPH_H_LOG2 = 3,
  parameter int TAG_W        = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_is_sprite;
  logic [FRAME_W-1:0]      in_frame;
  logic [DIM_W-1:0]        in_height;
  logic [DIM_W-1:0]        in_width;
  logic [DIM_W-1:0]        in_x;
  logic [DIM_W-1:0]        in_y;
  logic [ADDR_W-1:0]       in_base;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_W-1:0]       out_addr;
  logic [GLYPH_W_LOG2-1:0] out_glyph_x;
  logic [GLYPH_H_LOG2-1:0] out_glyph_y;
  logic                    out_oob;
  logic                    out_ovf;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_is_sprite, in_frame, in_height, in_width,
           in_x, in_y, in_base, in_tag, out_ready,
    input  in_ready, out_valid, out_addr, out_glyph_x, out_glyph_y,
           out_oob, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_is_sprite, in_frame, in_height, in_width,
           in_x, in_y, in_base, in_tag, out_ready,
    output in_ready, out_valid, out_addr, out_glyph_x, out_glyph_y,
           out_oob, out_ovf, out_tag
  );
endinterface

// File: rtl/layer_addr_pipe.sv
// Pipelined sprite/text layer RAM address generator.
// Input register, then three compute stages; the whole pipe freezes while the
// output is held by the consumer, so latency is exactly three cycles unstalled.
module layer_addr_pipe #(
  parameter int DIM_W        = 16,
  parameter int FRAME_W      = 8,
  parameter int ADDR_W       = 27,
  parameter int BPP_LOG2     = 1,
  parameter int GLYPH_W_LOG2 = 3,
  parameter int GLYPH_H_LOG2 = 3,
  parameter int CHAR_B_LOG2  = 0,
  parameter int TAG_W        = 4
) (
  input logic              clk,
  input logic              rst,
  layer_addr_pipe_if.slave bus
);
  localparam int PROD_W = 2 * DIM_W;
  localparam int IDX_W  = FRAME_W + 2 * DIM_W + 1;
  localparam int SH_MAX = (BPP_LOG2 > CHAR_B_LOG2) ? BPP_LOG2 : CHAR_B_LOG2;
  localparam int OFF_W  = IDX_W + SH_MAX;
  localparam int SUM_W  = ((ADDR_W > OFF_W) ? ADDR_W : OFF_W) + 1;

  // Splits the full-width sum into {overflow, truncated address}.
  function automatic logic [ADDR_W:0] fit_addr(input logic [SUM_W-1:0] sum);
    return {|sum[SUM_W-1:ADDR_W], sum[ADDR_W-1:0]};
  endfunction

  logic adv;
  logic vld_p0, vld_p1, vld_p2, vld_p3;

  // A result held at the output blocks every stage behind it.
  assign adv          = !(vld_p3 && !bus.out_ready);
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_p3;

  // Valid bits advance together and are flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= bus.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- input register ----
  logic                    spr_p0;
  logic [FRAME_W-1:0]      frame_p0;
  logic [DIM_W-1:0]        h_p0, w_p0, x_p0, y_p0;
  logic [ADDR_W-1:0]       base_p0;
  logic [TAG_W-1:0]        tag_p0;

  // Capture the query on acceptance.
  always_ff @(posedge clk) begin
    if (adv) begin
      spr_p0   <= bus.in_is_sprite;
      frame_p0 <= bus.in_frame;
      h_p0     <= bus.in_height;
      w_p0     <= bus.in_width;
      x_p0     <= bus.in_x;
      y_p0     <= bus.in_y;
      base_p0  <= bus.in_base;
      tag_p0   <= bus.in_tag;
    end
  end

  // ---- S1: products, bounds, text cell coordinates ----
  logic                    spr_p1, oob_p1;
  logic [FRAME_W-1:0]      frame_p1;
  logic [PROD_W-1:0]       yw_p1, hw_p1;
  logic [DIM_W-1:0]        x_p1, cols_p1, cx_p1, cy_p1;
  logic [ADDR_W-1:0]       base_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic [GLYPH_W_LOG2-1:0] gx_p1;
  logic [GLYPH_H_LOG2-1:0] gy_p1;

  // Zero width or height makes every coordinate out of bounds.
  always_ff @(posedge clk) begin
    if (adv) begin
      spr_p1   <= spr_p0;
      frame_p1 <= frame_p0;
      yw_p1    <= PROD_W'(y_p0) * PROD_W'(w_p0);
      hw_p1    <= PROD_W'(h_p0) * PROD_W'(w_p0);
      oob_p1   <= (x_p0 >= w_p0) || (y_p0 >= h_p0);
      x_p1     <= x_p0;
      cols_p1  <= w_p0 >> GLYPH_W_LOG2;
      cx_p1    <= x_p0 >> GLYPH_W_LOG2;
      cy_p1    <= y_p0 >> GLYPH_H_LOG2;
      base_p1  <= base_p0;
      tag_p1   <= tag_p0;
      gx_p1    <= x_p0[GLYPH_W_LOG2-1:0];
      gy_p1    <= y_p0[GLYPH_H_LOG2-1:0];
    end
  end

  // ---- S2: linear pixel / cell index at full width ----
  logic                    spr_p2, oob_p2;
  logic [IDX_W-1:0]        idx_p2;
  logic [ADDR_W-1:0]       base_p2;
  logic [TAG_W-1:0]        tag_p2;
  logic [GLYPH_W_LOG2-1:0] gx_p2;
  logic [GLYPH_H_LOG2-1:0] gy_p2;

  // Sprite: frame*(h*w) + y*w + x. Text: cy*cols + cx (cols may be zero).
  always_ff @(posedge clk) begin
    if (adv) begin
      spr_p2  <= spr_p1;
      oob_p2  <= oob_p1;
      idx_p2  <= spr_p1 ? IDX_W'(frame_p1) * IDX_W'(hw_p1) + IDX_W'(yw_p1) + IDX_W'(x_p1)
                        : IDX_W'(cy_p1) * IDX_W'(cols_p1) + IDX_W'(cx_p1);
      base_p2 <= base_p1;
      tag_p2  <= tag_p1;
      gx_p2   <= gx_p1;
      gy_p2   <= gy_p1;
    end
  end

  // ---- S3: byte offset, base add, output register ----
  logic [SUM_W-1:0]        off_s3, sum_s3;
  logic [ADDR_W:0]         fit_s3;
  logic [ADDR_W-1:0]       addr_p3;
  logic [GLYPH_W_LOG2-1:0] gx_p3;
  logic [GLYPH_H_LOG2-1:0] gy_p3;
  logic                    oob_p3, ovf_p3;
  logic [TAG_W-1:0]        tag_p3;

  assign off_s3 = spr_p2 ? (SUM_W'(idx_p2) << BPP_LOG2) : (SUM_W'(idx_p2) << CHAR_B_LOG2);
  assign sum_s3 = SUM_W'(base_p2) + off_s3;
  assign fit_s3 = fit_addr(sum_s3);

  // Out-of-bounds results point at the layer base with flags and glyph cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      addr_p3 <= '0;
      gx_p3   <= '0;
      gy_p3   <= '0;
      oob_p3  <= 1'b0;
      ovf_p3  <= 1'b0;
      tag_p3  <= '0;
    end else if (adv) begin
      vld_p3  <= vld_p2;
      addr_p3 <= oob_p2 ? base_p2 : fit_s3[ADDR_W-1:0];
      ovf_p3  <= !oob_p2 && fit_s3[ADDR_W];
      gx_p3   <= (oob_p2 || spr_p2) ? '0 : gx_p2;
      gy_p3   <= (oob_p2 || spr_p2) ? '0 : gy_p2;
      oob_p3  <= oob_p2;
      tag_p3  <= tag_p2;
    end
  end

  assign bus.out_addr    = addr_p3;
  assign bus.out_glyph_x = gx_p3;
  assign bus.out_glyph_y = gy_p3;
  assign bus.out_oob     = oob_p3;
  assign bus.out_ovf     = ovf_p3;
  assign bus.out_tag     = tag_p3;
endmodule

// File: tb/tb_layer_addr_pipe.sv
// Scoreboard bench for layer_addr_pipe: directed queries push expected results,
// a negedge monitor pops and compares each transferred result.
module tb_layer_addr_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_addr_pipe_if ifc ();
  layer_addr_pipe dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [26:0] addr;
    logic [2:0]  gx;
    logic [2:0]  gy;
    logic        oob;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  exp_t sbq[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  logic held = 1'b0;
  logic [38:0] snap;

  function automatic exp_t mk(input logic [26:0] a, input logic [2:0] gx, input logic [2:0] gy,
                              input logic oob, input logic ovf, input logic [3:0] tag);
    exp_t e;
    e.addr = a; e.gx = gx; e.gy = gy; e.oob = oob; e.ovf = ovf; e.tag = tag;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic spr, input logic [7:0] fr, input logic [15:0] h,
                       input logic [15:0] w, input logic [15:0] x, input logic [15:0] y,
                       input logic [26:0] base, input logic [3:0] tag);
    ifc.in_is_sprite = spr; ifc.in_frame = fr; ifc.in_height = h; ifc.in_width = w;
    ifc.in_x = x; ifc.in_y = y; ifc.in_base = base; ifc.in_tag = tag;
  endtask

  // Offer one query and block until it is accepted; expected result queued on acceptance.
  task automatic send(input logic spr, input logic [7:0] fr, input logic [15:0] h,
                      input logic [15:0] w, input logic [15:0] x, input logic [15:0] y,
                      input logic [26:0] base, input logic [3:0] tag, input exp_t e);
    int n;
    n = 0;
    drive(spr, fr, h, w, x, y, base, tag);
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!ifc.in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout tag=%0d: in_ready stuck low", tag);
    end else sbq.push_back(e);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (sbq.size() != 0) begin
      total_cnt++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string name);
    @(posedge clk); #1 check({name, "_n1"}, ifc.out_valid, 0);
    @(posedge clk); #1 check({name, "_n2"}, ifc.out_valid, 0);
    @(posedge clk); #1 check({name, "_n3"}, ifc.out_valid, 1);
  endtask

  // Monitor: compares transferred results and checks outputs stay frozen under stall.
  always @(negedge clk) begin
    exp_t e;
    if (rst) held = 1'b0;
    else begin
      if (ifc.out_valid && !ifc.out_ready) begin
        check("stall_in_ready", ifc.in_ready, 0);
        if (held)
          check("stall_hold", {ifc.out_addr, ifc.out_glyph_x, ifc.out_glyph_y,
                               ifc.out_oob, ifc.out_ovf, ifc.out_tag}, snap);
        snap = {ifc.out_addr, ifc.out_glyph_x, ifc.out_glyph_y,
                ifc.out_oob, ifc.out_ovf, ifc.out_tag};
        held = 1'b1;
      end else held = 1'b0;
      if (ifc.out_valid && ifc.out_ready) begin
        if (sbq.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got tag %0d, expected no result", ifc.out_tag);
        end else begin
          e = sbq.pop_front();
          check($sformatf("tag[exp%0d]", e.tag), ifc.out_tag, e.tag);
          check($sformatf("addr[tag%0d]", e.tag), ifc.out_addr, e.addr);
          check($sformatf("glyph_x[tag%0d]", e.tag), ifc.out_glyph_x, e.gx);
          check($sformatf("glyph_y[tag%0d]", e.tag), ifc.out_glyph_y, e.gy);
          check($sformatf("oob[tag%0d]", e.tag), ifc.out_oob, e.oob);
          check($sformatf("ovf[tag%0d]", e.tag), ifc.out_ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sx;
    logic [26:0] sa;
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    drive(1'b0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 27'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", ifc.out_valid, 0);
    check("reset_in_ready", ifc.in_ready, 1);
    check("reset_out_addr", ifc.out_addr, 0);
    check("reset_out_tag", ifc.out_tag, 0);
    check("reset_flags", {ifc.out_oob, ifc.out_ovf, ifc.out_glyph_x, ifc.out_glyph_y}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Sprite frame 2 of 16x16 at (3,5), base 0x100: 0x100 + (595<<1) = 0x5A6, three-cycle latency.
    send(1'b1, 8'd2, 16'd16, 16'd16, 16'd3, 16'd5, 27'h100, 4'd1, mk(27'h5A6, 0, 0, 0, 0, 4'd1));
    check_latency("lat_sprite");
    drain();

    // Text 640 wide, (17,9): cols 80, cell 82, glyph (1,1).
    send(1'b0, 8'd7, 16'd480, 16'd640, 16'd17, 16'd9, 27'h0, 4'd2, mk(27'd82, 3'd1, 3'd1, 0, 0, 4'd2));
    // x == width: out of bounds, address = base.
    send(1'b1, 8'd1, 16'd16, 16'd16, 16'd16, 16'd0, 27'h200, 4'd3, mk(27'h200, 0, 0, 1, 0, 4'd3));
    // Zero width: always out of bounds.
    send(1'b1, 8'd0, 16'd16, 16'd0, 16'd0, 16'd0, 27'h300, 4'd4, mk(27'h300, 0, 0, 1, 0, 4'd4));
    // Frame 255 of 65535x65535: true sum 0x1FDFC0401FE, low 27 bits 0x40401FE.
    send(1'b1, 8'd255, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 27'h0, 4'd5, mk(27'h40401FE, 0, 0, 0, 1, 4'd5));
    // Text narrower than one glyph: cols 0, cell = cx = 0, glyph (3,1).
    send(1'b0, 8'd0, 16'd100, 16'd5, 16'd3, 16'd9, 27'h40, 4'd6, mk(27'h40, 3'd3, 3'd1, 0, 0, 4'd6));
    drain();

    // Eight back-to-back sprite queries with a five-cycle output stall mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          sx = (i == 5) ? 16'd4 : 16'(i % 4);
          sa = (i == 5) ? 27'h1000 : 27'h1000 + 27'((i * 16 + 4 + int'(sx)) * 2);
          send(1'b1, 8'(i), 16'd4, 16'd4, sx, 16'd1, 27'h1000, 4'(i),
               mk(sa, 0, 0, (i == 5), 0, 4'(i)));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 ifc.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 ifc.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three queries in flight and a competing query on the input.
    send(1'b1, 8'd0, 16'd8, 16'd8, 16'd1, 16'd1, 27'h0, 4'd9, mk(27'd18, 0, 0, 0, 0, 4'd9));
    send(1'b1, 8'd0, 16'd8, 16'd8, 16'd2, 16'd1, 27'h0, 4'd10, mk(27'd20, 0, 0, 0, 0, 4'd10));
    send(1'b1, 8'd0, 16'd8, 16'd8, 16'd3, 16'd1, 27'h0, 4'd11, mk(27'd22, 0, 0, 0, 0, 4'd11));
    drive(1'b1, 8'd0, 16'd8, 16'd8, 16'd4, 16'd1, 27'h0, 4'd15);
    ifc.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    check("midrst_out_valid", ifc.out_valid, 0);
    check("midrst_in_ready", ifc.in_ready, 1);
    check("midrst_out_tag", ifc.out_tag, 0);
    check("midrst_out_addr", ifc.out_addr, 0);
    rst = 1'b0;
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 8'd2, 16'd16, 16'd16, 16'd3, 16'd5, 27'h100, 4'd12, mk(27'h5A6, 0, 0, 0, 0, 4'd12));
    check_latency("lat_after_rst");
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
